multicycle_cpu: RTL and testbench

- Multi-cycle MIPS-subset core, the next generation after the team's single-cycle CPU.
- Controlled by an FSM (FETCH/DECODE/EXEC/MEM/WB); one shared ALU; one unified external memory port with req/ack handshake, so memory may stall for any number of cycles.
- Parametrised in reset vector and register-file depth.
- Adds two things the single-cycle design lacks: a trap state for illegal instructions and wait-state tolerance.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/mc_regfile.sv | 25 ++
 rtl/multicycle_cpu.sv | 152 +++++++++++++++
 tb/tb_multicycle_cpu.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared FSM states, opcode/funct constants and ALU for the multi-cycle core
package cpu_pkg;
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL} alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                           OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22,
                           FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        return op == OP_RTYPE ? fn inside {FN_SLL, FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}
                              : op inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
                                           OP_ORI, OP_LW, OP_SW};
    endfunction

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
        return op == ALU_SUB ? a - b :
               op == ALU_AND ? a & b :
               op == ALU_OR  ? a | b :
               op == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} :
               op == ALU_SLL ? b << sh : a + b;
    endfunction
endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: REG_NUM x 32 register file, two async reads, one sync write, $0 hardwired to zero
module mc_regfile #(
    parameter int REG_NUM = 32,
    localparam int RW = $clog2(REG_NUM)
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic [RW-1:0] ra,
    input  logic [RW-1:0] rb,
    input  logic          we,
    input  logic [RW-1:0] wa,
    input  logic [31:0]   wd,
    output logic [31:0]   rda,
    output logic [31:0]   rdb
);
    logic [31:0] regs [REG_NUM];

    always_ff @(posedge CLK) begin
        if (Reset) regs <= '{default: '0};
        else if (we && wa != '0) regs[wa] <= wd;
    end

    assign rda = ra == '0 ? '0 : regs[ra];
    assign rdb = rb == '0 ? '0 : regs[rb];
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: FSM-sequenced MIPS-subset core with one shared ALU and a req/ack memory port.
// Defining PERF_CNT_EN adds the cycle_cnt/instret_cnt performance counters.
module multicycle_cpu import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          REG_NUM  = 32,
    parameter int          ADDR_W   = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       currentAddress,
    output logic [2:0]        state,
`ifdef PERF_CNT_EN
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instret_cnt,
`endif
    output logic              trap
);
    localparam int RW = $clog2(REG_NUM);

    state_t      st, nst;
    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [31:0] rda, rdb, alu_a, alu_b, alu_y, simm, zimm, jt, rf_wd, addr_full;
    logic [4:0]  rf_wa;
    alu_op_t     alu_op, r_op, i_op;
    logic        done, rf_we, taken;
    logic        is_r, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_mem, is_ctl;

    wire [5:0] op = ir[31:26];
    wire [4:0] rs = ir[25:21];
    wire [4:0] rt = ir[20:16];
    wire [4:0] rd = ir[15:11];
    wire [4:0] sh = ir[10:6];
    wire [5:0] fn = ir[5:0];

    assign simm   = {{16{ir[15]}}, ir[15:0]};
    assign zimm   = {16'd0, ir[15:0]};
    assign jt     = {pc[31:28], ir[25:0], 2'b00};
    assign is_r   = op == OP_RTYPE;
    assign is_jr  = is_r && fn == FN_JR;
    assign is_j   = op == OP_J;
    assign is_jal = op == OP_JAL;
    assign is_beq = op == OP_BEQ;
    assign is_bne = op == OP_BNE;
    assign is_lw  = op == OP_LW;
    assign is_sw  = op == OP_SW;
    assign is_mem = is_lw || is_sw;
    assign is_ctl = is_jr || is_j || is_jal || is_beq || is_bne;
    assign taken  = is_beq ? a == b : a != b;

    // Reset gates the request so a pending ack can never land while Reset is asserted
    assign mem_req        = (st == FETCH || st == MEM) && !Reset;
    assign mem_we         = mem_req && st == MEM && is_sw;
    assign addr_full      = (st == FETCH ? pc : alu_out) & ~32'h3;
    assign mem_addr       = addr_full[ADDR_W-1:0];
    assign mem_wdata      = b;
    assign done           = mem_req && mem_ack;
    assign currentAddress = pc;
    assign state          = st;
    assign trap           = st == TRAP;

    assign r_op = fn == FN_SUB ? ALU_SUB : fn == FN_AND ? ALU_AND : fn == FN_OR ? ALU_OR :
                  fn == FN_SLT ? ALU_SLT : fn == FN_SLL ? ALU_SLL : ALU_ADD;
    assign i_op = op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : ALU_ADD;

    // The single ALU computes PC+4 in FETCH, the branch target in DECODE and the result in EXEC
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = pc;
        alu_b  = 32'd4;
        if (st == DECODE) alu_b = simm << 2;
        else if (st == EXEC) begin
            alu_op = is_r ? r_op : i_op;
            alu_a  = a;
            alu_b  = is_r ? b : (op == OP_ANDI || op == OP_ORI) ? zimm : simm;
        end
    end

    assign alu_y = alu(alu_op, alu_a, alu_b, sh);

    assign rf_we = st == WB || (st == EXEC && is_jal);
    assign rf_wa = st == EXEC ? 5'd31 : is_r ? rd : rt;
    assign rf_wd = st == EXEC ? pc : is_lw ? mdr : alu_out;

    mc_regfile #(.REG_NUM(REG_NUM)) u_regfile (
        .CLK   (CLK),
        .Reset (Reset),
        .ra    (rs[RW-1:0]),
        .rb    (rt[RW-1:0]),
        .we    (rf_we),
        .wa    (rf_wa[RW-1:0]),
        .wd    (rf_wd),
        .rda   (rda),
        .rdb   (rdb)
    );

    always_comb begin
        nst = st;
        case (st)
            FETCH:   nst = done ? DECODE : FETCH;
            DECODE:  nst = is_legal(op, fn) ? EXEC : TRAP;
            EXEC:    nst = is_mem ? MEM : is_ctl ? FETCH : WB;
            MEM:     nst = !done ? MEM : is_sw ? FETCH : WB;
            WB:      nst = FETCH;
            default: nst = TRAP;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            st      <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            st <= nst;
            if (st == FETCH && done) begin
                ir <= mem_rdata;
                pc <= alu_y;
            end
            if (st == DECODE) begin
                a       <= rda;
                b       <= rdb;
                alu_out <= alu_y;
            end
            if (st == EXEC && !is_ctl) alu_out <= alu_y;
            if (st == EXEC && is_ctl) pc <= is_jr ? a : (is_j || is_jal) ? jt : taken ? alu_out : pc;
            if (st == MEM && done && is_lw) mdr <= mem_rdata;
        end
    end

`ifdef PERF_CNT_EN
    // An instruction retires whenever FETCH is re-entered from EXEC, MEM or WB
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (st != TRAP) cycle_cnt <= cycle_cnt + 32'd1;
            if (nst == FETCH && st != FETCH) instret_cnt <= instret_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed table-driven and sequence checks of multicycle_cpu with a wait-state memory model
module tb_multicycle_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ack, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
    logic [2:0]  state;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_cpu #(.RESET_PC(32'h100), .REG_NUM(32), .ADDR_W(32)) dut (
        .CLK            (clk),
        .Reset          (rst),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .currentAddress (pc),
        .state          (state),
`ifdef PERF_CNT_EN
        .cycle_cnt      (cycle_cnt),
        .instret_cnt    (instret_cnt),
`endif
        .trap           (trap)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    int unsigned ack_delay = 0;
    int unsigned wait_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    int          checks = 0, errors = 0;

    assign mem_ack   = mem_req && (wait_cnt >= ack_delay);
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
        if (mem_req && mem_ack && mem_we) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
    end

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] stw;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] w);
        mem[addr[11:2]] = w;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_store(input string name, input logic [31:0] addr, input logic [31:0] exp);
        int  start;
        bit  seen;
        start = wr_cnt;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            tick();
            if (wr_cnt != start) seen = 1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no store within 200 cycles", name);
        end else begin
            chk({name, "_addr"}, wr_addr, addr);
            chk({name, "_data"}, wr_data, exp);
        end
    endtask

    initial begin
        int bad;
        vecs[0]  = '{32'h00221820, 32'hAC030308, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
        vecs[1]  = '{32'h00221822, 32'hAC030308, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
        vecs[2]  = '{32'h00221824, 32'hAC030308, 32'hF0F0FFFF, 32'h0FF000FF, 32'h00F000FF};
        vecs[3]  = '{32'h00221825, 32'hAC030308, 32'hF0000000, 32'h0000000F, 32'hF000000F};
        vecs[4]  = '{32'h0022182A, 32'hAC030308, 32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vecs[5]  = '{32'h0022182A, 32'hAC030308, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        vecs[6]  = '{32'h00021900, 32'hAC030308, 32'h00000000, 32'h80000001, 32'h00000010};
        vecs[7]  = '{32'h2023FFFD, 32'hAC030308, 32'h0000000A, 32'h00000000, 32'h00000007};
        vecs[8]  = '{32'h3023FF0F, 32'hAC030308, 32'hFFFFFFFF, 32'h00000000, 32'h0000FF0F};
        vecs[9]  = '{32'h34238000, 32'hAC030308, 32'h12340000, 32'h00000000, 32'h12348000};
        vecs[10] = '{32'h20200005, 32'hAC000308, 32'h00000009, 32'h00000000, 32'h00000000};
        for (int i = 0; i < 1024; i++) mem[i] = '0;

        // reset state and first fetch
        repeat (2) tick();
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_pc", pc, 32'h100);
        rst = 1'b0;
        #1;
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h100);
        chk("first_we", {31'd0, mem_we}, 32'd0);

        // addi/addi/add timing, zero wait states
        load(32'h100, 32'h20010005);
        load(32'h104, 32'h20020007);
        load(32'h108, 32'h00221820);
        load(32'h10C, 32'hAC030200);
        load(32'h110, 32'h1000FFFF);
        do_reset();
        repeat (11) tick();
        chk("seq_wb_state", {29'd0, state}, 32'd4);
        tick();
        chk("seq_fetch_state", {29'd0, state}, 32'd0);
        chk("seq_pc", pc, 32'h10C);
`ifdef PERF_CNT_EN
        chk("perf_cycle", cycle_cnt, 32'd12);
        chk("perf_instret", instret_cnt, 32'd3);
`endif
        wait_store("seq_sum", 32'h200, 32'd12);

        // ALU / immediate vectors: operands loaded with lw, result stored with sw
        foreach (vecs[i]) begin
            load(32'h100, 32'h8C010300);
            load(32'h104, 32'h8C020304);
            load(32'h108, vecs[i].instr);
            load(32'h10C, vecs[i].stw);
            load(32'h110, 32'h1000FFFF);
            load(32'h300, vecs[i].opa);
            load(32'h304, vecs[i].opb);
            do_reset();
            wait_store($sformatf("vec%0d", i), 32'h308, vecs[i].exp);
        end

        // lw with 3 wait states on every access
        ack_delay = 3;
        load(32'h008, 32'hDEADBEEF);
        load(32'h100, 32'h8C040008);
        load(32'h104, 32'hAC040200);
        load(32'h108, 32'h1000FFFF);
        do_reset();
        bad = 0;
        for (int t = 0; t <= 11; t++) begin
            if (t <= 3 && (state != 3'd0 || !mem_req || mem_addr != 32'h100)) bad++;
            if (t >= 6 && t <= 9 && (state != 3'd3 || !mem_req || mem_we || mem_addr != 32'h8)) bad++;
            if (t == 10) chk("lw_wb_state", {29'd0, state}, 32'd4);
            if (t < 11) tick();
        end
        chk("lw_addr_stable", bad, 0);
        chk("lw_done_state", {29'd0, state}, 32'd0);
        chk("lw_done_pc", pc, 32'h104);
        wait_store("lw_value", 32'h200, 32'hDEADBEEF);
        ack_delay = 0;

        // beq loop returns every 3 cycles
        load(32'h100, 32'h20010003);
        load(32'h104, 32'h1021FFFF);
        do_reset();
        repeat (4) tick();
        chk("beq_entry_pc", pc, 32'h104);
        for (int k = 0; k < 3; k++) begin
            repeat (3) tick();
            chk($sformatf("beq_loop%0d_pc", k), pc, 32'h104);
            chk($sformatf("beq_loop%0d_state", k), {29'd0, state}, 32'd0);
        end

        // bne with equal operands falls through
        load(32'h104, 32'h14210005);
        load(32'h108, 32'h1000FFFF);
        do_reset();
        repeat (7) tick();
        chk("bne_pc", pc, 32'h108);
        chk("bne_state", {29'd0, state}, 32'd0);

        // j -> jal -> jr round trip
        load(32'h100, 32'h08000004);
        load(32'h010, 32'h0C000010);
        load(32'h040, 32'h03E00008);
        load(32'h014, 32'hAC1F0200);
        load(32'h018, 32'h1000FFFF);
        do_reset();
        repeat (3) tick();
        chk("j_pc", pc, 32'h10);
        repeat (3) tick();
        chk("jal_pc", pc, 32'h40);
        repeat (3) tick();
        chk("jr_pc", pc, 32'h14);
        wait_store("jal_link", 32'h200, 32'h14);

        // illegal opcode traps and stays quiet until reset
        load(32'h100, 32'hFC000000);
        do_reset();
        repeat (2) tick();
        chk("trap_state", {29'd0, state}, 32'd7);
        chk("trap_flag", {31'd0, trap}, 32'd1);
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (mem_req || state != 3'd7 || !trap) bad++;
        end
        chk("trap_quiet", bad, 0);
`ifdef PERF_CNT_EN
        chk("perf_trap_cycle", cycle_cnt, 32'd2);
`endif
        rst = 1'b1;
        tick();
        chk("trap_clear", {31'd0, trap}, 32'd0);
        chk("trap_rst_state", {29'd0, state}, 32'd0);
        rst = 1'b0;
        #1;
        chk("trap_refetch_req", {31'd0, mem_req}, 32'd1);
        chk("trap_refetch_addr", mem_addr, 32'h100);

        // illegal R-type funct also traps
        load(32'h100, 32'h0000003F);
        do_reset();
        repeat (2) tick();
        chk("funct_trap", {31'd0, trap}, 32'd1);

        // reset during a stalled fetch drops the request
        load(32'h100, 32'h20010003);
        ack_delay = 5;
        do_reset();
        repeat (2) tick();
        chk("stall_req", {31'd0, mem_req}, 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_pc", pc, 32'h100);
        rst = 1'b0;
        ack_delay = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
